// File: rtl/mor1kx_wb_commit_marocchino.sv
// Write-back commit stage: LSU > MCLK > ALU arbitration into the WB register set.
// Optional GPR busy scoreboard for DECODE hazards, built when MOR1KX_WB_SCOREBOARD_EN is defined.
module mor1kx_wb_commit_marocchino #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            padv_wb_i,
    input  logic                            pipeline_flush_i,
    input  logic                            alu_valid_i,
    input  logic                            alu_rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] alu_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] alu_result_i,
    output logic                            alu_ack_o,
    input  logic                            mclk_valid_i,
    input  logic                            mclk_rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] mclk_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] mclk_result_i,
    output logic                            mclk_ack_o,
    input  logic                            lsu_valid_i,
    input  logic                            lsu_rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] lsu_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_result_i,
    output logic                            lsu_ack_o,
    input  logic                            dcod_issue_i,
    input  logic                            dcod_rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] dcod_rfd_adr_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] dcod_rfa_adr_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] dcod_rfb_adr_i,
    output logic                            dcod_rfa_busy_o,
    output logic                            dcod_rfb_busy_o,
    output logic                            dcod_rfd_busy_o,
    output logic                            wb_new_result_o,
    output logic                            wb_rf_wb_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wb_result_o
);

    // Handshake: a unit holds valid with stable fields until its ack is seen high
    // on a clock edge; ack is combinational and never asserted during reset or flush.
    logic                            commit;
    logic                            win_rf_wb;
    logic [OPTION_RF_ADDR_WIDTH-1:0] win_rfd_adr;
    logic [OPTION_OPERAND_WIDTH-1:0] win_result;

    logic                            wb_new_result_q, wb_new_result_d;
    logic                            wb_rf_wb_q, wb_rf_wb_d;
    logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_q, wb_rfd_adr_d;
    logic [OPTION_OPERAND_WIDTH-1:0] wb_result_q, wb_result_d;

    assign commit = rst_n & padv_wb_i & ~pipeline_flush_i &
                    (lsu_valid_i | mclk_valid_i | alu_valid_i);

    assign lsu_ack_o  = commit & lsu_valid_i;
    assign mclk_ack_o = commit & ~lsu_valid_i & mclk_valid_i;
    assign alu_ack_o  = commit & ~lsu_valid_i & ~mclk_valid_i & alu_valid_i;

    always_comb begin
        win_rf_wb   = alu_rf_wb_i;
        win_rfd_adr = alu_rfd_adr_i;
        win_result  = alu_result_i;
        if (lsu_valid_i) begin
            win_rf_wb   = lsu_rf_wb_i;
            win_rfd_adr = lsu_rfd_adr_i;
            win_result  = lsu_result_i;
        end else if (mclk_valid_i) begin
            win_rf_wb   = mclk_rf_wb_i;
            win_rfd_adr = mclk_rfd_adr_i;
            win_result  = mclk_result_i;
        end
    end

    always_comb begin
        wb_new_result_d = 1'b0;
        wb_rf_wb_d      = 1'b0;
        wb_rfd_adr_d    = wb_rfd_adr_q;
        wb_result_d     = wb_result_q;
        if (commit) begin
            wb_new_result_d = 1'b1;
            wb_rf_wb_d      = win_rf_wb & (win_rfd_adr != '0);
            wb_rfd_adr_d    = win_rfd_adr;
            wb_result_d     = win_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_new_result_q <= 1'b0;
            wb_rf_wb_q      <= 1'b0;
            wb_rfd_adr_q    <= '0;
            wb_result_q     <= '0;
        end else begin
            wb_new_result_q <= wb_new_result_d;
            wb_rf_wb_q      <= wb_rf_wb_d;
            wb_rfd_adr_q    <= wb_rfd_adr_d;
            wb_result_q     <= wb_result_d;
        end
    end

    assign wb_new_result_o = wb_new_result_q;
    assign wb_rf_wb_o      = wb_rf_wb_q;
    assign wb_rfd_adr_o    = wb_rfd_adr_q;
    assign wb_result_o     = wb_result_q;

`ifdef MOR1KX_WB_SCOREBOARD_EN
    localparam int NUM_GPR = 1 << OPTION_RF_ADDR_WIDTH;

    logic [NUM_GPR-1:0] busy_q, busy_d;

    // Clear before set so a re-issue to the committing register stays busy.
    always_comb begin
        busy_d = busy_q;
        if (pipeline_flush_i) begin
            busy_d = '0;
        end else begin
            if (commit & win_rf_wb)
                busy_d[win_rfd_adr] = 1'b0;
            if (dcod_issue_i & dcod_rf_wb_i & (dcod_rfd_adr_i != '0))
                busy_d[dcod_rfd_adr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign dcod_rfa_busy_o = busy_q[dcod_rfa_adr_i];
    assign dcod_rfb_busy_o = busy_q[dcod_rfb_adr_i];
    assign dcod_rfd_busy_o = busy_q[dcod_rfd_adr_i];
`else
    logic unused_dcod;
    assign unused_dcod = ^{dcod_issue_i, dcod_rf_wb_i, dcod_rfd_adr_i,
                           dcod_rfa_adr_i, dcod_rfb_adr_i};

    assign dcod_rfa_busy_o = 1'b0;
    assign dcod_rfb_busy_o = 1'b0;
    assign dcod_rfd_busy_o = 1'b0;
`endif

endmodule
